uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Wishbone-slave transmit buffer that sits directly upstream of the simpleuart data register.
- Software pushes bytes into a power-of-two FIFO.
- A drain FSM presents bytes to the UART core's data-write port and honours its wait handshake, so the CPU need not poll per byte.
- Provides status/count, a sticky overflow flag, flush, and a level interrupt when the FIFO empties.

Parameters:
BASE_ADR, 32'h2000_0100, Wishbone base address of this block
DATA, 8'h00, offset of the push register (write-only; reads return 0)
STATUS, 8'h04, offset of the status register
CTRL, 8'h08, offset of the control register
DEPTH_LOG2, 4, log2 of FIFO depth (legal range 1..7; depth = 2**DEPTH_LOG2)

Ports:
clk  in  1  single clock for all logic
resetn  in  1  asynchronous active-low reset
wb_adr_i  in  32  Wishbone byte address
wb_dat_i  in  32  Wishbone write data
wb_sel_i  in  4  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  registered single-cycle acknowledge
wb_dat_o  out  32  read data, valid while wb_ack_o=1
uart_enabled  in  1  UART core enable; draining is gated by this
uart_dat_we  out  1  byte-present strobe to the UART core data write
uart_dat_di  out  32  {24'b0, head byte}
uart_dat_wait  in  1  UART core busy; a byte is accepted on a cycle where uart_dat_we=1 and uart_dat_wait=0
irq  out  1  level interrupt = irq_en & empty

Behaviour:
- Reset (async assert, sync release):
  - Outputs: wb_ack_o=0, wb_dat_o=0, uart_dat_we=0, uart_dat_di=0, irq=0.
  - State: FIFO empty, pointers 0, count 0, overflow=0, irq_en=0, FSM=IDLE.
- Address decode:
  - hit = cyc & stb & (wb_adr_i == BASE_ADR|offset), full 32-bit compare.
  - Unmapped addresses are never acked.
- Ack:
  - wb_ack_o rises the cycle after a hit while wb_ack_o=0.
  - It stays high one cycle, so each access takes 2 cycles minimum.
  - Register side effects occur on the cycle wb_ack_o is high; the access takes effect exactly once.
- DATA write (sel[0]=1):
  - If not full, push wb_dat_i[7:0].
  - If full, drop the byte and set overflow=1. Ack is still returned; the bus never stalls.
  - sel[0]=0: no effect.
- STATUS read layout:
  - [7:0] count, zero-extended, width DEPTH_LOG2+1.
  - [8] empty, [9] full, [10] overflow, [11] busy (FSM=PRESENT).
  - Other bits 0.
- STATUS write with sel[1]=1 and wb_dat_i[10]=1: clears overflow (W1C).
- CTRL read: [0] irq_en.
- CTRL write with sel[0]=1:
  - irq_en <= wb_dat_i[0].
  - wb_dat_i[1]=1 requests a flush (self-clearing, reads 0).
- Drain FSM, state IDLE:
  - uart_dat_we=0.
  - If !empty & uart_enabled: load uart_dat_di from the head entry and go to PRESENT next cycle.
- Drain FSM, state PRESENT:
  - uart_dat_we=1 and uart_dat_di is held stable.
  - On accept (uart_dat_wait=0): pop the head.
    - If a further entry exists and uart_enabled=1, load it and stay in PRESENT (back-to-back presentation; the UART's wait then throttles).
    - Otherwise go to IDLE.
  - uart_enabled dropping while in PRESENT does not withdraw the byte; the FSM stays until accept.
- Simultaneous push and pop: count unchanged, both take effect.
- Push when full is rejected even if a pop occurs the same cycle (full is the registered flag).
- Flush:
  - Pointers reset, count=0, FSM->IDLE, uart_dat_we=0 the following cycle.
  - If the UART accepts a byte in the flush cycle, that byte is transmitted; no other byte is.
  - A push in the same cycle as a flush is discarded.
  - Overflow is unaffected.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count ranges 0..depth.
  - full = (count == depth).
  - empty = (count == 0).
- Reset mid-transfer: uart_dat_we drops immediately (async); the FIFO contents are lost.

Test Plan:
- Reset, uart_enabled=1, uart_dat_wait=0; write DATA 0x41 -> ack 1 cycle after stb; uart_dat_we=1 with uart_dat_di=0x41 for one cycle, 2 cycles after ack; STATUS reads count=0, empty=1.
- uart_enabled=0; push 16 bytes 0x00..0x0F, then push 0xAA -> STATUS = 0x610 (count 16, full, overflow); write STATUS 0x400 -> overflow reads 0; 0xAA is never presented.
- Preload 3 bytes, enable, hold uart_dat_wait=1 for 20 cycles -> uart_dat_we stays 1 with the first byte stable; release wait -> bytes presented in order with no byte lost or duplicated.
- FIFO holding 5 bytes, wait=1, CTRL write 0x2 -> uart_dat_we=0 the next cycle; count=0; none of the 5 bytes is accepted.
- irq_en=1 with an empty FIFO -> irq=1; push a byte with uart_enabled=0 -> irq=0; enable and drain -> irq returns to 1 on the cycle the pop brings count to 0.
- Continuous push while draining: 40 bytes pushed and 40 pops over wrap-around -> order preserved, pointers wrap cleanly, no overflow.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Wishbone bus bundle for uart_tx_fifo; the block sits on the slave side.
interface uart_tx_fifo_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Wishbone-fed transmit FIFO that drains bytes into the simpleuart data register,
// with status/count, sticky overflow, flush and an empty-level interrupt.
module uart_tx_fifo #(
  parameter logic [31:0] BASE_ADR   = 32'h2000_0100,
  parameter logic [7:0]  DATA       = 8'h00,
  parameter logic [7:0]  STATUS     = 8'h04,
  parameter logic [7:0]  CTRL       = 8'h08,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         resetn,
  uart_tx_fifo_if.slave wb,
  input  logic         uart_enabled,
  output logic         uart_dat_we,
  output logic [31:0]  uart_dat_di,
  input  logic         uart_dat_wait,
  output logic         irq
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(1) << DEPTH_LOG2;
  localparam logic [31:0] ADR_DATA   = BASE_ADR | {24'h0, DATA};
  localparam logic [31:0] ADR_STATUS = BASE_ADR | {24'h0, STATUS};
  localparam logic [31:0] ADR_CTRL   = BASE_ADR | {24'h0, CTRL};

  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_next;

  logic [7:0]            mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, load_ptr;
  logic [CW-1:0]         count;
  logic                  overflow, irq_en, empty, full;
  logic                  sel_data, sel_status, sel_ctrl, hit, access, wr_access;
  logic                  push_req, push, pop, flush, ovf_clr, load;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign sel_data   = (wb.wb_adr_i == ADR_DATA);
  assign sel_status = (wb.wb_adr_i == ADR_STATUS);
  assign sel_ctrl   = (wb.wb_adr_i == ADR_CTRL);
  assign hit        = wb.wb_cyc_i & wb.wb_stb_i & (sel_data | sel_status | sel_ctrl);

  // Side effects fire on the ack cycle so each bus access acts exactly once.
  assign access    = hit & wb.wb_ack_o;
  assign wr_access = access & wb.wb_we_i;
  assign push_req  = wr_access & sel_data & wb.wb_sel_i[0];
  assign flush     = wr_access & sel_ctrl & wb.wb_sel_i[0] & wb.wb_dat_i[1];
  assign push      = push_req & ~full & ~flush;
  assign ovf_clr   = wr_access & sel_status & wb.wb_sel_i[1] & wb.wb_dat_i[10];

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign pop         = (state == PRESENT) & ~uart_dat_wait;
  assign uart_dat_we = (state == PRESENT);
  assign irq         = irq_en & empty;
  assign unused_bits = ^{wb.wb_dat_i[31:11], wb.wb_dat_i[9:8], wb.wb_sel_i[3:2]};

  always_comb begin
    rdata = '0;
    if (!wb.wb_we_i) begin
      if (sel_status)
        rdata = {20'h0, (state == PRESENT), overflow, full, empty, 8'(count)};
      else if (sel_ctrl)
        rdata = {31'h0, irq_en};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= hit & ~wb.wb_ack_o;
      wb.wb_dat_o <= (hit & ~wb.wb_ack_o) ? rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wb.wb_dat_i[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      if (push_req & full)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
      if (wr_access & sel_ctrl & wb.wb_sel_i[0])
        irq_en <= wb.wb_dat_i[0];
    end
  end

  // On accept, the next entry sits one past the head being popped.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_ptr   = rd_ptr;
    case (state)
      IDLE: begin
        if (!empty && uart_enabled) begin
          state_next = PRESENT;
          load       = 1'b1;
        end
      end
      PRESENT: begin
        if (!uart_dat_wait) begin
          if ((count > CW'(1)) && uart_enabled) begin
            load     = 1'b1;
            load_ptr = rd_ptr + DEPTH_LOG2'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      load       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      uart_dat_di <= '0;
    end else begin
      state <= state_next;
      if (load)
        uart_dat_di <= {24'h0, mem[load_ptr]};
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;
  localparam logic [31:0] A_DATA   = 32'h2000_0100;
  localparam logic [31:0] A_STATUS = 32'h2000_0104;
  localparam logic [31:0] A_CTRL   = 32'h2000_0108;
  localparam logic [31:0] A_BAD    = 32'h2000_010C;
  localparam logic [31:0] A_ALIAS  = 32'h3000_0100;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_enabled = 1'b0;
  logic        wait_cmd = 1'b0;
  logic        rand_mode = 1'b0;
  logic        rand_wait = 1'b0;
  logic        uart_dat_wait;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        irq;

  assign uart_dat_wait = rand_mode ? rand_wait : wait_cmd;

  uart_tx_fifo_if bus ();

  uart_tx_fifo dut (
    .clk(clk),
    .resetn(resetn),
    .wb(bus),
    .uart_enabled(uart_enabled),
    .uart_dat_we(uart_dat_we),
    .uart_dat_di(uart_dat_di),
    .uart_dat_wait(uart_dat_wait),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc_cnt = 0;
  int last_ack_cyc = 0;

  // Reference model: the FIFO is just a queue of bytes plus two flags.
  logic [7:0]  q_m[$];
  logic [7:0]  tx_log[$];
  bit          ovf_m = 0, irq_en_m = 0, exp_ack = 0, exp_read = 0;
  logic [31:0] exp_rdata = '0;
  bit          edge_we = 0, edge_wait = 0, edge_flush = 0;
  logic [31:0] edge_di = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_hit();
    return bus.wb_cyc_i && bus.wb_stb_i &&
           (bus.wb_adr_i == A_DATA || bus.wb_adr_i == A_STATUS || bus.wb_adr_i == A_CTRL);
  endfunction

  // Model update on every clock edge from the values seen just before the edge.
  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      q_m.delete();
      ovf_m = 0; irq_en_m = 0; exp_ack = 0; exp_read = 0; exp_rdata = '0;
      edge_we = 0; edge_wait = 0; edge_flush = 0;
    end else begin
      bit hit, wr, full_pre, nxt_ack;
      logic [31:0] rd;
      cyc_cnt++;
      hit      = is_hit();
      wr       = hit && exp_ack && bus.wb_we_i;
      full_pre = (q_m.size() == DEPTH);
      nxt_ack  = hit && !exp_ack;
      rd       = '0;
      if (bus.wb_adr_i == A_STATUS)
        rd = 32'(q_m.size()) + (q_m.size() == 0 ? 256 : 0) + (full_pre ? 512 : 0) + (ovf_m ? 1024 : 0);
      else if (bus.wb_adr_i == A_CTRL)
        rd = {31'h0, irq_en_m};
      edge_we = uart_dat_we; edge_wait = uart_dat_wait; edge_di = uart_dat_di; edge_flush = 0;
      if (uart_dat_we && !uart_dat_wait && q_m.size() > 0)
        tx_log.push_back(q_m.pop_front());
      if (wr && bus.wb_adr_i == A_DATA && bus.wb_sel_i[0]) begin
        if (full_pre) ovf_m = 1;
        else q_m.push_back(bus.wb_dat_i[7:0]);
      end
      if (wr && bus.wb_adr_i == A_STATUS && bus.wb_sel_i[1] && bus.wb_dat_i[10])
        ovf_m = 0;
      if (wr && bus.wb_adr_i == A_CTRL && bus.wb_sel_i[0]) begin
        irq_en_m = bus.wb_dat_i[0];
        if (bus.wb_dat_i[1]) begin
          q_m.delete();
          edge_flush = 1;
        end
      end
      exp_ack   = nxt_ack;
      exp_read  = nxt_ack && !bus.wb_we_i;
      exp_rdata = rd;
    end
  end

  // Per-cycle compare at the falling edge; the busy bit is pinned by directed checks.
  initial forever begin
    @(negedge clk);
    if (resetn) begin
      check_output("wb_ack", {31'h0, bus.wb_ack_o}, {31'h0, exp_ack});
      if (exp_read && bus.wb_ack_o)
        check_output("wb_read", bus.wb_dat_o & 32'hFFFF_F7FF, exp_rdata);
      check_output("irq", {31'h0, irq}, {31'h0, irq_en_m && q_m.size() == 0});
      if (uart_dat_we) begin
        check_output("present_nonempty", {31'h0, q_m.size() != 0}, 32'h1);
        if (q_m.size() != 0)
          check_output("present_byte", uart_dat_di, {24'h0, q_m[0]});
      end
      if (edge_flush)
        check_output("we_after_flush", {31'h0, uart_dat_we}, 32'h0);
      else if (edge_we && edge_wait) begin
        check_output("we_held", {31'h0, uart_dat_we}, 32'h1);
        check_output("di_stable", uart_dat_di, edge_di);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    rand_wait = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic bus_access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, input bit expect_ack, output logic [31:0] rdat);
    int start;
    bit got;
    got = 0;
    @(negedge clk);
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel; bus.wb_we_i = we;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    start = cyc_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        got = 1;
        break;
      end
    end
    rdat = bus.wb_dat_o;
    if (expect_ack) begin
      check_output("ack_seen", {31'h0, got}, 32'h1);
      if (got) begin
        check_output("ack_latency", cyc_cnt - start, 32'd1);
        last_ack_cyc = cyc_cnt;
        @(negedge clk);
      end
    end else begin
      check_output("unmapped_no_ack", {31'h0, got}, 32'h0);
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; bus.wb_sel_i = '0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    bus_access(adr, dat, sel, 1'b1, 1'b1, d);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    bus_access(adr, 32'h0, 4'hF, 1'b0, 1'b1, d);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      if (q_m.size() == 0 && !uart_dat_we) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    check_output("drain_done", {31'h0, done}, 32'h1);
  endtask

  // Random bus traffic with random UART enable/wait; the model checks every cycle.
  task automatic apply_stimulus(input int n_ops);
    logic [31:0] d;
    rand_mode = 1'b1;
    for (int i = 0; i < n_ops; i++) begin
      int r;
      uart_enabled = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: wb_write(A_DATA, $urandom, 4'($urandom_range(0, 15)) | 4'h1);
        4: wb_write(A_DATA, $urandom, 4'($urandom_range(0, 15)));
        5: wb_read(A_STATUS, d);
        6: wb_read(A_CTRL, d);
        7: wb_write(A_STATUS, $urandom & 32'h0000_0400, 4'($urandom_range(0, 15)));
        8: wb_write(A_CTRL, ($urandom & 32'h1) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0),
                    4'($urandom_range(0, 15)) | 4'h1);
        default: bus_access(A_BAD, $urandom, 4'hF, $urandom_range(0, 1) == 1, 1'b0, d);
      endcase
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  burst [40];
    int base, n;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
    check_output("rst_dat_o", bus.wb_dat_o, 32'h0);
    check_output("rst_we", {31'h0, uart_dat_we}, 32'h0);
    check_output("rst_di", uart_dat_di, 32'h0);
    check_output("rst_irq", {31'h0, irq}, 32'h0);
    resetn = 1'b1;
    wb_read(A_STATUS, d); check_output("status_reset", d, 32'h100);
    wb_read(A_CTRL, d);   check_output("ctrl_reset", d, 32'h0);

    // Single byte: presented two cycles after the ack, for exactly one cycle
    uart_enabled = 1'b1; wait_cmd = 1'b0;
    wb_write(A_DATA, 32'h41, 4'h1);
    n = 0;
    while (!uart_dat_we && n < 10) begin @(negedge clk); n++; end
    check_output("t1_we", {31'h0, uart_dat_we}, 32'h1);
    check_output("t1_we_delay", cyc_cnt - last_ack_cyc, 32'd2);
    check_output("t1_di", uart_dat_di, 32'h41);
    @(negedge clk);
    check_output("t1_we_one_cycle", {31'h0, uart_dat_we}, 32'h0);
    wb_read(A_STATUS, d); check_output("t1_status", d, 32'h100);

    // Fill, overflow, W1C clear, unmapped and aliased addresses
    uart_enabled = 1'b0;
    for (int i = 0; i < 16; i++) wb_write(A_DATA, i, 4'h1);
    wb_write(A_DATA, 32'hAA, 4'h1);
    wb_read(A_STATUS, d); check_output("t2_status_full_ovf", d, 32'h610);
    wb_write(A_STATUS, 32'h400, 4'h2);
    wb_read(A_STATUS, d); check_output("t2_status_ovf_clr", d, 32'h210);
    wb_read(A_DATA, d);   check_output("t2_data_reads_0", d, 32'h0);
    bus_access(A_BAD, 32'h0, 4'hF, 1'b0, 1'b0, d);
    bus_access(A_ALIAS, 32'h55, 4'hF, 1'b1, 1'b0, d);
    base = tx_log.size();
    uart_enabled = 1'b1;
    wait_drain();
    check_output("t2_tx_count", tx_log.size() - base, 32'd16);
    for (int i = 0; i < 16 && base + i < tx_log.size(); i++)
      check_output("t2_tx_byte", {24'h0, tx_log[base + i]}, i);

    // Held wait: first byte stays presented, then all three drain in order
    uart_enabled = 1'b0; wait_cmd = 1'b1;
    wb_write(A_DATA, 32'h31, 4'h1);
    wb_write(A_DATA, 32'h32, 4'h1);
    wb_write(A_DATA, 32'h33, 4'h1);
    base = tx_log.size();
    uart_enabled = 1'b1;
    repeat (20) @(negedge clk);
    check_output("t3_we_held", {31'h0, uart_dat_we}, 32'h1);
    check_output("t3_di_first", uart_dat_di, 32'h31);
    wb_read(A_STATUS, d); check_output("t3_status_busy", d, 32'h803);
    wait_cmd = 1'b0;
    wait_drain();
    check_output("t3_tx_count", tx_log.size() - base, 32'd3);
    for (int i = 0; i < 3 && base + i < tx_log.size(); i++)
      check_output("t3_tx_byte", {24'h0, tx_log[base + i]}, 32'h31 + i);

    // Flush while the UART is stalled
    uart_enabled = 1'b0; wait_cmd = 1'b1;
    for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'h10 + i, 4'h1);
    base = tx_log.size();
    uart_enabled = 1'b1;
    repeat (3) @(negedge clk);
    check_output("t4_we_before", {31'h0, uart_dat_we}, 32'h1);
    wb_write(A_CTRL, 32'h2, 4'h1);
    check_output("t4_we_after", {31'h0, uart_dat_we}, 32'h0);
    wb_read(A_STATUS, d); check_output("t4_status", d, 32'h100);
    wb_read(A_CTRL, d);   check_output("t4_flush_reads_0", d, 32'h0);
    wait_cmd = 1'b0;
    repeat (5) @(negedge clk);
    check_output("t4_none_sent", tx_log.size() - base, 32'd0);

    // Empty-level interrupt
    wb_write(A_CTRL, 32'h1, 4'h1);
    check_output("t5_irq_empty", {31'h0, irq}, 32'h1);
    uart_enabled = 1'b0;
    wb_write(A_DATA, 32'h55, 4'h1);
    check_output("t5_irq_pending", {31'h0, irq}, 32'h0);
    base = tx_log.size();
    uart_enabled = 1'b1;
    n = 0;
    while (!irq && n < 20) begin @(negedge clk); n++; end
    check_output("t5_irq_back", {31'h0, irq}, 32'h1);
    check_output("t5_tx_one", tx_log.size() - base, 32'd1);
    wb_write(A_CTRL, 32'h0, 4'h1);

    // Continuous push while draining across pointer wrap
    rand_mode = 1'b1;
    base = tx_log.size();
    for (int i = 0; i < 40; i++) begin
      burst[i] = 8'($urandom);
      wb_write(A_DATA, {24'h0, burst[i]}, 4'h1);
    end
    rand_mode = 1'b0; wait_cmd = 1'b0;
    wait_drain();
    check_output("t6_tx_count", tx_log.size() - base, 32'd40);
    for (int i = 0; i < 40 && base + i < tx_log.size(); i++)
      check_output("t6_tx_byte", {24'h0, tx_log[base + i]}, {24'h0, burst[i]});
    wb_read(A_STATUS, d); check_output("t6_status", d, 32'h100);

    apply_stimulus(300);
    uart_enabled = 1'b1; wait_cmd = 1'b0;
    wait_drain();

    // Reset while a byte is being presented
    uart_enabled = 1'b0; wait_cmd = 1'b1;
    wb_write(A_DATA, 32'h77, 4'h1);
    uart_enabled = 1'b1;
    repeat (3) @(negedge clk);
    check_output("t7_we_before", {31'h0, uart_dat_we}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check_output("t7_we_async", {31'h0, uart_dat_we}, 32'h0);
    check_output("t7_di_async", uart_dat_di, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    wb_read(A_STATUS, d); check_output("t7_status", d, 32'h100);
    wb_read(A_CTRL, d);   check_output("t7_ctrl", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
